register_file_param: RTL and testbench

Parametrised successor to the 16x16 two-read-port register file. It generalises data width and depth, and adds a write enable, an optional hardwired zero register and optional write-to-read bypass. A sequenced clear engine zeroes storage after reset or on request, while `busy` tells the datapath to stall. The block sits in the CPU datapath between decode (register addresses) and the ALU/writeback stage.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/register_file_param_if.sv | 27 ++
 rtl/regfile_clear_seq.sv | 52 +++++
 rtl/register_file_param.sv | 87 ++++++++
 tb/tb_register_file_param.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the parametrised register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

endpackage

// File: rtl/register_file_param_if.sv
// Datapath-side bundle of the register file: decode/writeback drive, register file answers.
interface register_file_param_if import regfile_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              clear;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] read1;
  logic [ADDR_W-1:0] read2;
  logic [DATA_W-1:0] regOutA;
  logic [DATA_W-1:0] regOutB;
  logic              busy;

  modport master (
    output clear, writeEnable, writeReg, writeData, read1, read2,
    input  regOutA, regOutB, busy
  );

  modport slave (
    input  clear, writeEnable, writeReg, writeData, read1, read2,
    output regOutA, regOutB, busy
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every address once writing zero, after reset or a clear request.
//   state    | meaning
//   RF_IDLE  | normal operation, user writes allowed, clear sampled
//   RF_CLEAR | zeroing mem[cnt] each edge, busy high, clear/writes ignored
module regfile_clear_seq import regfile_pkg::*; #(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= RF_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clear) begin
            state <= RF_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          cnt <= cnt + 1'b1;
          // last location is written on this edge; the counter wrap is never seen
          if (cnt == '1) begin
            state <= RF_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RF_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/register_file_param.sv
// Parametrised two-read/one-write register file with optional zero register,
// optional write-to-read bypass and a sequenced clear engine.
module register_file_param import regfile_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  register_file_param_if.slave rf
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;

  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic              userWrite;
  logic              zeroDrop;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clearSeq (
    .CLK      (CLK),
    .reset    (reset),
    .clear    (rf.clear),
    .busy     (busy),
    .clr_we   (clrWe),
    .clr_addr (clrAddr)
  );

  assign rf.busy = busy;

  // Reset and a clear request both win over a same-cycle user write.
  assign zeroDrop  = (ZERO_REG != 0) && (rf.writeReg == '0);
  assign userWrite = rf.writeEnable && !rf.clear && !reset && !zeroDrop;

  always_comb begin
    memWe   = 1'b0;
    memAddr = '0;
    memData = '0;
    if (clrWe) begin
      memWe   = 1'b1;
      memAddr = clrAddr;
    end else if (userWrite) begin
      memWe   = 1'b1;
      memAddr = rf.writeReg;
      memData = rf.writeData;
    end
  end

  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  always_comb begin
    rf.regOutA = mem[rf.read1];
    if (busy) begin
      rf.regOutA = '0;
    end else if ((ZERO_REG != 0) && (rf.read1 == '0)) begin
      rf.regOutA = '0;
    end else if ((BYPASS != 0) && rf.writeEnable && (rf.writeReg == rf.read1)) begin
      rf.regOutA = rf.writeData;
    end
  end

  always_comb begin
    rf.regOutB = mem[rf.read2];
    if (busy) begin
      rf.regOutB = '0;
    end else if ((ZERO_REG != 0) && (rf.read2 == '0)) begin
      rf.regOutB = '0;
    end else if ((BYPASS != 0) && rf.writeEnable && (rf.writeReg == rf.read2)) begin
      rf.regOutB = rf.writeData;
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: defaults, no-zero/no-bypass, and 32x32 variants.
module tb_register_file_param;
  import regfile_pkg::*;

  logic CLK = 1'b0;
  logic rstA, rstB, rstC;

  always #5 CLK = ~CLK;

  register_file_param_if #(.DATA_W(16), .ADDR_W(4)) ifA ();
  register_file_param_if #(.DATA_W(16), .ADDR_W(4)) ifB ();
  register_file_param_if #(.DATA_W(32), .ADDR_W(5)) ifC ();

  register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1))
    dutA (.CLK(CLK), .reset(rstA), .rf(ifA));
  register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0))
    dutB (.CLK(CLK), .reset(rstB), .rf(ifB));
  register_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
    dutC (.CLK(CLK), .reset(rstC), .rf(ifC));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];
  int checks = 0;
  int errors = 0;
  int n;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(input logic [31:0] obs);
    sbEntry_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h", obs);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (obs === e.exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  function automatic logic busyOf(input int d);
    case (d)
      0:       return ifA.busy;
      1:       return ifB.busy;
      default: return ifC.busy;
    endcase
  endfunction

  // Counts samples with busy high, starting at the current sample; bounded.
  task automatic busyLen(input int d, output int cnt);
    cnt = 0;
    while (busyOf(d) === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    {ifA.clear, ifA.writeEnable, ifA.writeReg, ifA.writeData, ifA.read1, ifA.read2} = '0;
    {ifB.clear, ifB.writeEnable, ifB.writeReg, ifB.writeData, ifB.read1, ifB.read2} = '0;
    {ifC.clear, ifC.writeEnable, ifC.writeReg, ifC.writeData, ifC.read1, ifC.read2} = '0;

    // ---------------- DUT A: defaults ----------------
    push("A_rst_busy", 32'd1);
    push("A_rst_outA", 32'd0);
    push("A_rst_outB", 32'd0);
    tick();
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    check({31'd0, ifA.busy});
    check({16'd0, ifA.regOutA});
    check({16'd0, ifA.regOutB});
    push("A_rst_busy_len", 32'd16);
    busyLen(0, n);
    check(n);

    for (int i = 0; i < 16; i++) begin
      ifA.read1 = 4'(i);
      ifA.read2 = 4'(15 - i);
      push($sformatf("A_clr_rdA_%0d", i), 32'd0);
      push($sformatf("A_clr_rdB_%0d", i), 32'd0);
      #1;
      check({16'd0, ifA.regOutA});
      check({16'd0, ifA.regOutB});
    end

    ifA.writeEnable = 1'b1; ifA.writeReg = 4'd5; ifA.writeData = 16'hBEEF;
    tick();
    ifA.writeReg = 4'd9; ifA.writeData = 16'h1234;
    tick();
    ifA.writeEnable = 1'b0;
    ifA.read1 = 4'd5; ifA.read2 = 4'd9;
    push("A_wr_r5", 32'h0000BEEF);
    push("A_wr_r9", 32'h00001234);
    #1;
    check({16'd0, ifA.regOutA});
    check({16'd0, ifA.regOutB});
    ifA.read2 = 4'd5;
    push("A_same_A", 32'h0000BEEF);
    push("A_same_B", 32'h0000BEEF);
    #1;
    check({16'd0, ifA.regOutA});
    check({16'd0, ifA.regOutB});

    // zero register beats bypass, and the write is dropped
    ifA.writeEnable = 1'b1; ifA.writeReg = 4'd0; ifA.writeData = 16'hFFFF; ifA.read1 = 4'd0;
    push("A_zero_bypass", 32'd0);
    #1;
    check({16'd0, ifA.regOutA});
    tick();
    ifA.writeEnable = 1'b0;
    push("A_zero_after", 32'd0);
    #1;
    check({16'd0, ifA.regOutA});

    ifA.writeEnable = 1'b1; ifA.writeReg = 4'd3; ifA.writeData = 16'hA5A5;
    ifA.read1 = 4'd3; ifA.read2 = 4'd3;
    push("A_bypass_A", 32'h0000A5A5);
    push("A_bypass_B", 32'h0000A5A5);
    #1;
    check({16'd0, ifA.regOutA});
    check({16'd0, ifA.regOutB});
    tick();
    ifA.writeEnable = 1'b0;
    push("A_bypass_stored", 32'h0000A5A5);
    #1;
    check({16'd0, ifA.regOutA});

    // clear beats a same-cycle write; writes and clear pulses during busy are ignored
    ifA.clear = 1'b1; ifA.writeEnable = 1'b1; ifA.writeReg = 4'd2; ifA.writeData = 16'h7777;
    ifA.read1 = 4'd5; ifA.read2 = 4'd2;
    tick();
    ifA.clear = 1'b0;
    push("A_busy_rdA", 32'd0);
    push("A_busy_rdB", 32'd0);
    check({16'd0, ifA.regOutA});
    check({16'd0, ifA.regOutB});
    n = 0;
    while (ifA.busy === 1'b1 && n < 200) begin
      n++;
      ifA.clear = (n == 5);
      ifA.writeEnable = 1'b1; ifA.writeReg = 4'd2; ifA.writeData = 16'h7777;
      tick();
    end
    ifA.clear = 1'b0; ifA.writeEnable = 1'b0;
    push("A_clear_busy_len", 32'd16);
    check(n);
    push("A_after_clr_r5", 32'd0);
    push("A_after_clr_r2", 32'd0);
    #1;
    check({16'd0, ifA.regOutA});
    check({16'd0, ifA.regOutB});
    push("A_idle_stays", 32'd0);
    tick();
    check({31'd0, ifA.busy});

    // ---------------- DUT B: ZERO_REG=0, BYPASS=0 ----------------
    busyLen(1, n);
    push("B_idle", 32'd0);
    check({31'd0, ifB.busy});
    ifB.writeEnable = 1'b1; ifB.writeReg = 4'd0; ifB.writeData = 16'hFFFF; ifB.read1 = 4'd0;
    push("B_r0_before", 32'd0);
    #1;
    check({16'd0, ifB.regOutA});
    tick();
    ifB.writeEnable = 1'b0;
    push("B_r0_after", 32'h0000FFFF);
    #1;
    check({16'd0, ifB.regOutA});
    ifB.writeEnable = 1'b1; ifB.writeReg = 4'd3; ifB.writeData = 16'hA5A5; ifB.read1 = 4'd3;
    push("B_nobypass_old", 32'd0);
    #1;
    check({16'd0, ifB.regOutA});
    tick();
    ifB.writeEnable = 1'b0;
    push("B_nobypass_new", 32'h0000A5A5);
    #1;
    check({16'd0, ifB.regOutA});

    // ---------------- DUT C: 32-bit x 32 entries ----------------
    busyLen(2, n);
    ifC.writeEnable = 1'b1; ifC.writeReg = 5'd20; ifC.writeData = 32'hDEADBEEF;
    tick();
    ifC.writeReg = 5'd31; ifC.writeData = 32'hCAFEF00D;
    tick();
    ifC.writeEnable = 1'b0;
    ifC.read1 = 5'd20; ifC.read2 = 5'd31;
    push("C_wr_r20", 32'hDEADBEEF);
    push("C_wr_r31", 32'hCAFEF00D);
    #1;
    check(ifC.regOutA);
    check(ifC.regOutB);
    ifC.clear = 1'b1;
    tick();
    ifC.clear = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rstC = 1'b1;
    tick();
    rstC = 1'b0;
    push("C_reset_busy_len", 32'd32);
    busyLen(2, n);
    check(n);
    for (int i = 0; i < 32; i++) begin
      ifC.read1 = 5'(i);
      ifC.read2 = 5'(31 - i);
      push($sformatf("C_clr_rdA_%0d", i), 32'd0);
      push($sformatf("C_clr_rdB_%0d", i), 32'd0);
      #1;
      check(ifC.regOutA);
      check(ifC.regOutB);
    end

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
